// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: memory access size codes, store-buffer entry type and size-to-length helper
// Shared by the store buffer and the data memory so both agree on access sizes.
package riscv_mem_pkg;
    typedef enum logic [2:0] {
        SZ_WORD   = 3'b000,
        SZ_BYTE   = 3'b001,
        SZ_HALF   = 3'b010,
        SZ_BYTE_U = 3'b011,
        SZ_HALF_U = 3'b100
    } mem_size_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
    } sb_entry_t;

    // Access length in bytes; unknown codes are treated as a full word.
    function automatic logic [2:0] size_len(input logic [2:0] size);
        return (size == SZ_BYTE || size == SZ_BYTE_U) ? 3'd1 :
               (size == SZ_HALF || size == SZ_HALF_U) ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_range_overlap.sv
// mem_range_overlap: flags whether two byte ranges [addr, addr+len-1] intersect
// Ports: a_addr/a_size, b_addr/b_size - the two accesses; overlap - ranges share a byte.
module mem_range_overlap
    import riscv_mem_pkg::*;
(
    input  logic [31:0] a_addr,
    input  logic [2:0]  a_size,
    input  logic [31:0] b_addr,
    input  logic [2:0]  b_size,
    output logic        overlap
);
    logic [32:0] a_lo, a_end, b_lo, b_end;

    // 33-bit ends so a range touching 0xFFFFFFFF does not wrap to zero.
    assign a_lo    = {1'b0, a_addr};
    assign b_lo    = {1'b0, b_addr};
    assign a_end   = a_lo + 33'(size_len(a_size));
    assign b_end   = b_lo + 33'(size_len(b_size));
    assign overlap = (a_lo < b_end) && (b_lo < a_end);
endmodule

// File: rtl/store_buffer.sv
// store_buffer: FIFO of pending stores sharing one data-memory port with loads
// Ports: CLK/RESET - clock, sync active-high reset; StoreValid/StoreAddress/StoreData/StoreSize - store request;
// LoadValid/LoadAddress/LoadSize - load request; Fence - wait for empty; Stall - request not accepted;
// MemAddress/MemWriteData/MemWriteEnable/MemSize - data-memory port.
module store_buffer
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        StoreValid,
    input  logic [31:0] StoreAddress,
    input  logic [31:0] StoreData,
    input  logic [2:0]  StoreSize,
    input  logic        LoadValid,
    input  logic [31:0] LoadAddress,
    input  logic [2:0]  LoadSize,
    input  logic        Fence,
    output logic        Stall,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWriteEnable,
    output logic [2:0]  MemSize
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    sb_entry_t        entries [DEPTH];
    sb_entry_t        head_e;
    logic [PW-1:0]    head, tail;
    logic [PW:0]      count;
    logic [DEPTH-1:0] live, hit;
    logic             hazard, load_go, drain, accept;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        // Slot i holds a pending store when its distance from head is below count.
        assign off     = PW'(i) - head;
        assign live[i] = {1'b0, off} < count;
        mem_range_overlap u_ov (
            .a_addr  (entries[i].addr),
            .a_size  (entries[i].size),
            .b_addr  (LoadAddress),
            .b_size  (LoadSize),
            .overlap (hit[i])
        );
    end

    assign head_e  = entries[head];
    assign hazard  = LoadValid & |(hit & live);
    assign load_go = LoadValid & ~hazard;
    // A stalled load leaves the port free, so draining continues until the hazard clears.
    assign drain   = ~load_go & (count != '0);
    assign accept  = StoreValid & ~LoadValid & (count < FULL);

    always_comb begin
        Stall          = ~RESET & ((LoadValid & hazard) | (StoreValid & (count == FULL)) |
                                   (Fence & (count != '0)) | (StoreValid & LoadValid));
        MemWriteEnable = ~RESET & drain;
        MemAddress     = RESET ? '0 : load_go ? LoadAddress : drain ? head_e.addr : '0;
        MemWriteData   = (RESET | load_go | ~drain) ? '0 : head_e.data;
        MemSize        = RESET ? '0 : load_go ? LoadSize : drain ? head_e.size : '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int k = 0; k < DEPTH; k++) entries[k] <= '0;
        end else begin
            if (accept) begin
                entries[tail] <= sb_entry_t'{addr: StoreAddress, data: StoreData, size: StoreSize};
                tail          <= tail + 1'b1;
            end
            if (drain) head <= head + 1'b1;
            count <= count + (PW+1)'(accept) - (PW+1)'(drain);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of store_buffer against a big-endian byte memory
module tb_store_buffer;
    logic        CLK = 1'b0;
    logic        RESET, StoreValid, LoadValid, Fence;
    logic [31:0] StoreAddress, StoreData, LoadAddress;
    logic [2:0]  StoreSize, LoadSize;
    logic        Stall, MemWriteEnable;
    logic [31:0] MemAddress, MemWriteData;
    logic [2:0]  MemSize;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit [7:0]    mem [bit [31:0]];

    always #5 CLK = ~CLK;

    store_buffer #(.DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .StoreValid(StoreValid), .StoreAddress(StoreAddress), .StoreData(StoreData), .StoreSize(StoreSize),
        .LoadValid(LoadValid), .LoadAddress(LoadAddress), .LoadSize(LoadSize), .Fence(Fence),
        .Stall(Stall), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWriteEnable(MemWriteEnable), .MemSize(MemSize)
    );

    always @(posedge CLK) begin
        if (MemWriteEnable) begin
            case (MemSize)
                3'b001, 3'b011: mem[MemAddress] = MemWriteData[7:0];
                3'b010, 3'b100: begin
                    mem[MemAddress]       = MemWriteData[15:8];
                    mem[MemAddress + 1]   = MemWriteData[7:0];
                end
                default: begin
                    mem[MemAddress]       = MemWriteData[31:24];
                    mem[MemAddress + 1]   = MemWriteData[23:16];
                    mem[MemAddress + 2]   = MemWriteData[15:8];
                    mem[MemAddress + 3]   = MemWriteData[7:0];
                end
            endcase
        end
    end

    function automatic bit [7:0] rb(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic bit [31:0] rd32(input bit [31:0] a);
        return {rb(a), rb(a + 1), rb(a + 2), rb(a + 3)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        StoreValid = 0; StoreAddress = 0; StoreData = 0; StoreSize = 0;
        LoadValid = 0; LoadAddress = 0; LoadSize = 0; Fence = 0;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        StoreValid = 1; StoreAddress = a; StoreData = d; StoreSize = s;
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] s);
        LoadValid = 1; LoadAddress = a; LoadSize = s;
    endtask

    initial begin
        idle();
        RESET = 1;
        st(32'h44, 32'h99, 3'b000);
        ld(32'h44, 3'b010);
        Fence = 1;
        #1;
        chk("rst_stall", Stall, 0);
        chk("rst_we", MemWriteEnable, 0);
        chk("rst_addr", MemAddress, 0);
        chk("rst_wdata", MemWriteData, 0);
        chk("rst_size", MemSize, 0);
        cyc(); RESET = 1;
        cyc(); RESET = 0;
        cyc();

        st(32'h10, 32'hDEADBEEF, 3'b000);
        #1;
        chk("w_stall", Stall, 0);
        chk("w_we_same", MemWriteEnable, 0);
        cyc(); #1;
        chk("w_we", MemWriteEnable, 1);
        chk("w_addr", MemAddress, 32'h10);
        chk("w_data", MemWriteData, 32'hDEADBEEF);
        chk("w_size", MemSize, 0);
        cyc(); #1;
        chk("w_we_after", MemWriteEnable, 0);
        chk("w_mem", rd32(32'h10), 32'hDEADBEEF);

        cyc();
        st(32'h60, 32'h55, 3'b000);
        ld(32'h60, 3'b000);
        #1;
        chk("ill_stall", Stall, 1);
        chk("ill_addr", MemAddress, 32'h60);
        chk("ill_we", MemWriteEnable, 0);
        cyc(); #1;
        chk("ill_dropped", MemWriteEnable, 0);

        cyc();
        st(32'h21, 32'hA5, 3'b001);
        #1;
        chk("b_stall", Stall, 0);
        cyc();
        ld(32'h20, 3'b000);
        #1;
        chk("haz_stall", Stall, 1);
        chk("haz_we", MemWriteEnable, 1);
        chk("haz_addr", MemAddress, 32'h21);
        chk("haz_data", MemWriteData, 32'hA5);
        chk("haz_size", MemSize, 3'b001);
        cyc();
        ld(32'h20, 3'b000);
        #1;
        chk("haz_clr_stall", Stall, 0);
        chk("haz_ld_addr", MemAddress, 32'h20);
        chk("haz_ld_we", MemWriteEnable, 0);
        chk("haz_ld_data", rd32(32'h20), 32'h00A50000);

        cyc();
        st(32'h30, 32'h1234, 3'b010);
        cyc();
        ld(32'h32, 3'b001);
        #1;
        chk("nh_stall", Stall, 0);
        chk("nh_addr", MemAddress, 32'h32);
        chk("nh_we", MemWriteEnable, 0);
        chk("nh_size", MemSize, 3'b001);
        cyc(); #1;
        chk("nh_drain_we", MemWriteEnable, 1);
        chk("nh_drain_addr", MemAddress, 32'h30);
        chk("nh_drain_data", MemWriteData, 32'h1234);
        chk("nh_drain_size", MemSize, 3'b010);
        cyc(); #1;
        chk("nh_mem", rd32(32'h30), 32'h12340000);

        cyc();
        st(32'h50, 32'hBEEF, 3'b010);
        cyc();
        ld(32'h51, 3'b011);
        #1;
        chk("hu_stall", Stall, 1);
        chk("hu_we", MemWriteEnable, 1);
        cyc();
        ld(32'h51, 3'b011);
        #1;
        chk("hu_stall2", Stall, 0);
        chk("hu_size", MemSize, 3'b011);

        cyc();
        st(32'h70, 32'h0, 3'b000);
        cyc();
        ld(32'h74, 3'b000);
        #1;
        chk("adj_stall", Stall, 0);
        chk("adj_addr", MemAddress, 32'h74);
        cyc();

        cyc();
        st(32'hFFFFFFFF, 32'h7E, 3'b001);
        cyc();
        ld(32'hFFFFFFFC, 3'b000);
        #1;
        chk("top_stall", Stall, 1);
        chk("top_drain", MemAddress, 32'hFFFFFFFF);
        cyc();
        ld(32'hFFFFFFFC, 3'b000);
        #1;
        chk("top_stall2", Stall, 0);
        chk("top_mem", rd32(32'hFFFFFFFC), 32'h0000007E);

        cyc();
        st(32'h80, 32'hCAFEF00D, 3'b000);
        cyc();
        Fence = 1;
        #1;
        chk("f_stall", Stall, 1);
        chk("f_we", MemWriteEnable, 1);
        cyc();
        Fence = 1;
        #1;
        chk("f_stall2", Stall, 0);
        chk("f_we2", MemWriteEnable, 0);

        for (int i = 0; i < 6; i++) begin
            cyc();
            st(32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 3'b000);
            #1;
            chk("wr_stall", Stall, 0);
            if (i > 0) begin
                chk("wr_we", MemWriteEnable, 1);
                chk("wr_addr", MemAddress, 32'h100 + 32'(4 * (i - 1)));
                chk("wr_data", MemWriteData, 32'h1000 + 32'(i - 1));
            end
        end
        cyc(); #1;
        chk("wr_last_addr", MemAddress, 32'h114);
        chk("wr_last_we", MemWriteEnable, 1);
        cyc(); #1;
        for (int i = 0; i < 6; i++) chk("wr_mem", rd32(32'h100 + 32'(4 * i)), 32'h1000 + 32'(i));

        cyc();
        st(32'h200, 32'h11111111, 3'b000);
        cyc();
        RESET = 1;
        #1;
        chk("rm_we", MemWriteEnable, 0);
        chk("rm_addr", MemAddress, 0);
        cyc();
        RESET = 0;
        #1;
        chk("rm_we2", MemWriteEnable, 0);
        Fence = 1;
        #1;
        chk("rm_fence", Stall, 0);
        cyc(); #1;
        chk("rm_we3", MemWriteEnable, 0);
        chk("rm_mem", rd32(32'h200), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
